// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back/commit stage.
package wb_pkg;

  // Commit FSM: normal retirement, or parked on an outstanding CSR transaction.
  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StCsrWait = 1'b1
  } wb_state_t;

  // CSR command carried down the pipe and forwarded to the CSR file.
  typedef enum logic [1:0] {
    CsrNone  = 2'd0,
    CsrWrite = 2'd1,
    CsrSet   = 2'd2,
    CsrClear = 2'd3
  } csr_op_t;

  // mcause code used for a failed or timed-out CSR access.
  localparam logic [3:0] ExcIllegalInstr = 4'd2;

  // mtvec[1:0] mode encodings; modes 2/3 behave like direct.
  localparam logic [1:0] MtvecDirect   = 2'd0;
  localparam logic [1:0] MtvecVectored = 2'd1;

endpackage

// File: rtl/irq_sync.sv
// Bank of flop-chain synchronisers for the asynchronous interrupt lines.
module irq_sync #(
  parameter int unsigned NUM_IRQ     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [NUM_IRQ-1:0] sync_irq
);

  // Stage 0 samples the raw line; the last stage feeds the arbiter.
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] stage_q;

  // Shift every line one stage per clock; reset clears the whole chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], irq};
    end
  end

  assign sync_irq = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_commit.sv
// Write-back/commit stage: retires MEM results, runs CSR req/ack transactions
// with a timeout, arbitrates interrupts/exceptions/mret and redirects fetch.
module wb_commit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned NUM_IRQ        = 3,
  parameter int unsigned IRQ_CAUSE_BASE = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CSR_TIMEOUT    = 15,
  parameter int unsigned CNT_W          = 64
) (
  input  logic               clk,
  input  logic               rst,
  // MEM -> WB pipe
  input  logic               wb_pipe_valid,
  output logic               wb_pipe_ready,
  output logic               wb_pipe_flush,
  input  logic [XLEN-1:0]    wb_pipe_pc,
  input  logic [XLEN-1:0]    wb_pipe_instruction,
  input  logic               wb_pipe_rd_write,
  input  logic [REG_AW-1:0]  wb_pipe_rd_addr,
  input  logic [XLEN-1:0]    wb_pipe_rd_data,
  input  logic [1:0]         wb_pipe_csr_op,
  input  logic [11:0]        wb_pipe_csr_addr,
  input  logic [XLEN-1:0]    wb_pipe_csr_info,
  input  logic               wb_pipe_mret,
  input  logic               wb_pipe_exc_pending,
  input  logic [3:0]         wb_pipe_exc_code,
  input  logic [XLEN-1:0]    wb_pipe_exc_tval,
  // Register file write port
  output logic               wb_rd_write,
  output logic [REG_AW-1:0]  wb_rd_addr,
  output logic [XLEN-1:0]    wb_rd_wdata,
  // CSR file transaction
  output logic               csr_req,
  output logic [1:0]         csr_op,
  output logic [11:0]        csr_addr,
  output logic [XLEN-1:0]    csr_wdata,
  input  logic               csr_ack,
  input  logic [XLEN-1:0]    csr_rdata,
  input  logic               csr_err,
  // CSR file state used for trap decisions
  input  logic               csr_mie_global,
  input  logic [NUM_IRQ-1:0] csr_irq_en,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  // Trap record towards the CSR file
  output logic               trap_take,
  output logic               trap_mret,
  output logic [XLEN-1:0]    trap_cause,
  output logic [XLEN-1:0]    trap_epc,
  output logic [XLEN-1:0]    trap_tval,
  // Fetch redirect
  output logic               wb_trap,
  output logic [XLEN-1:0]    wb_trap_pc,
  // Interrupts and counters
  input  logic [NUM_IRQ-1:0] irq,
  output logic [CNT_W-1:0]   wb_instret
);

  localparam int unsigned TmoW = (CSR_TIMEOUT < 1) ? 1 : $clog2(CSR_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(CSR_TIMEOUT);

  wb_state_t          state_q, state_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]   instret_q;
  logic               retire;

  logic [NUM_IRQ-1:0] sync_irq;
  logic [NUM_IRQ-1:0] irq_pend;
  int unsigned        irq_idx;
  logic [XLEN-1:0]    mtvec_base;

  irq_sync #(
    .NUM_IRQ     (NUM_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .sync_irq (sync_irq)
  );

  assign irq_pend   = sync_irq & csr_irq_en & {NUM_IRQ{csr_mie_global}};
  assign mtvec_base = {csr_mtvec[XLEN-1:2], 2'b00};

  // Lowest-index pending line wins.
  always_comb begin
    irq_idx = 0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_pend[i]) begin
        irq_idx = unsigned'(i);
      end
    end
  end

  // Command fields follow the pipe entry, which is held stable while stalled.
  assign csr_op    = csr_req ? wb_pipe_csr_op : CsrNone;
  assign csr_addr  = wb_pipe_csr_addr;
  assign csr_wdata = wb_pipe_csr_info;

  assign wb_pipe_flush = wb_trap;
  // Counter reads as zero during the reset cycle like the other outputs.
  assign wb_instret    = rst ? '0 : instret_q;

  // Next-state, arbitration and all combinational outputs.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    retire        = 1'b0;
    wb_pipe_ready = 1'b0;
    wb_rd_write   = 1'b0;
    wb_rd_addr    = wb_pipe_rd_addr;
    wb_rd_wdata   = wb_pipe_rd_data;
    csr_req       = 1'b0;
    trap_take     = 1'b0;
    trap_mret     = 1'b0;
    trap_cause    = '0;
    trap_epc      = wb_pipe_pc;
    trap_tval     = '0;
    wb_trap       = 1'b0;
    wb_trap_pc    = '0;

    if (!rst) begin
      unique case (state_q)
        StRun: begin
          tmo_d = '0;
          if (wb_pipe_valid) begin
            if (irq_pend != '0) begin
              trap_take  = 1'b1;
              trap_cause = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE + irq_idx)};
            end else if (wb_pipe_exc_pending) begin
              trap_take  = 1'b1;
              trap_cause = XLEN'(wb_pipe_exc_code);
              trap_tval  = wb_pipe_exc_tval;
            end else if (wb_pipe_mret) begin
              trap_mret     = 1'b1;
              wb_trap       = 1'b1;
              wb_trap_pc    = csr_mepc;
              wb_pipe_ready = 1'b1;
              retire        = 1'b1;
            end else if (csr_op_t'(wb_pipe_csr_op) != CsrNone) begin
              csr_req = 1'b1;
              state_d = StCsrWait;
            end else begin
              wb_pipe_ready = 1'b1;
              wb_rd_write   = wb_pipe_rd_write;
              retire        = 1'b1;
            end
          end
        end

        StCsrWait: begin
          csr_req = 1'b1;
          if (csr_ack && !csr_err) begin
            wb_rd_wdata   = csr_rdata;
            wb_rd_write   = wb_pipe_rd_write;
            wb_pipe_ready = 1'b1;
            retire        = 1'b1;
            state_d       = StRun;
          end else if (csr_ack || (tmo_q == TmoMax)) begin
            // On timeout the request is withdrawn so any late ack is ignored.
            csr_req    = csr_ack;
            trap_take  = 1'b1;
            trap_cause = XLEN'(ExcIllegalInstr);
            trap_tval  = wb_pipe_instruction;
            state_d    = StRun;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end

        default: state_d = StRun;
      endcase
    end

    // Taken traps consume the entry and vector through mtvec.
    if (trap_take) begin
      wb_trap       = 1'b1;
      wb_pipe_ready = 1'b1;
      case (csr_mtvec[1:0])
        MtvecDirect:   wb_trap_pc = mtvec_base;
        MtvecVectored: wb_trap_pc = trap_cause[XLEN-1] ?
                                    mtvec_base + {trap_cause[XLEN-3:0], 2'b00} : mtvec_base;
        default:       wb_trap_pc = mtvec_base;
      endcase
    end
  end

  // State, timeout and retire-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end

endmodule
